mem_writeback_stage: RTL and testbench
======================================

// Module: mem_writeback_stage
// PURPOSE
//   Data-memory access and write-back stage, downstream of MIPSALU.
//   - Takes the ALU result, store data (register-file B), destination register and CONTROL flags.
//   - Performs lw/sw against an internal big-endian byte-addressed data memory with a fixed wait-state latency.
//   - Returns the write-back triple (data, register, write strobe) to REGISTERS.
//   - Upstream flow control is a valid/ready handshake.
// PARAMETERS
//   MEM_BYTES    1024  data memory size in bytes; power of two
//   ADDR_W       10    byte address width = log2(MEM_BYTES)
//   WAIT_STATES  2     extra cycles per memory access, 0..15
// PORTS
//   CLK          in   1   clock, rising edge
//   RESET        in   1   asynchronous, active-low reset
//   in_valid     in   1   upstream operation valid
//   in_ready     out  1   stage can accept an operation
//   ALUOut       in   32  ALU result: write-back value or byte address
//   B            in   32  store data
//   WriteReg     in   5   destination register
//   MemRead      in   1   load word
//   MemWrite     in   1   store word
//   MemtoReg     in   1   1: write back load data; 0: write back ALUOut
//   RegWrite     in   1   operation writes the register file
//   WriteData    out  32  write-back data
//   WriteRegOut  out  5   write-back register
//   RegWriteOut  out  1   one-cycle write strobe to the register file
//   ERR          out  1   one-cycle error pulse (misaligned, or MemRead&MemWrite)
// BEHAVIOUR
//   Reset values
//   - While RESET=0: state IDLE, in_ready=0, WriteData=0, WriteRegOut=0, RegWriteOut=0, ERR=0, counter=0.
//   - Memory array is not affected by RESET; it is zero at time 0.
//   FSM IDLE -> ACCESS -> WB -> IDLE
//   - in_ready=1 only in IDLE with RESET=1.
//   - Accept when in_valid&in_ready; all inputs are captured on that edge.
//   - IDLE -> ACCESS if exactly one of MemRead/MemWrite is set and ALUOut[1:0]==0; counter loads WAIT_STATES.
//   - IDLE -> WB otherwise: non-memory op, misaligned access, or both flags set.
//   - ACCESS: counter decrements each cycle. When it is 0 the access commits and the state moves to WB.
//     ACCESS lasts WAIT_STATES+1 cycles.
//   - WB: outputs are valid for one cycle, then the state returns to IDLE.
//   Latency
//   - Accept edge N; strobes high in cycle N+1 for a non-memory op, N+2+WAIT_STATES for a memory op.
//   - Back-to-back accepts are never possible; the minimum initiation interval is 2 cycles.
//   Addressing
//   - addr = ALUOut[ADDR_W-1:0]; upper bits are ignored, so addresses wrap modulo MEM_BYTES.
//   - Big-endian: mem[addr]=bits 31:24 ... mem[addr+3]=bits 7:0.
//   Store commit
//   - Four bytes are written on the commit edge only. A store never asserts RegWriteOut.
//   Load commit
//   - The word is read on the commit edge into the data register.
//   - WriteData = MemtoReg ? load word : captured ALUOut.
//   Write strobe and error
//   - RegWriteOut = captured RegWrite & ~store & ~error.
//   - On error: no memory access, RegWriteOut=0, ERR=1 in WB; WriteData and WriteRegOut still show the captured values.
//   - Outside WB, RegWriteOut=0 and ERR=0; WriteData and WriteRegOut hold their last values.
//   Reset mid-operation
//   - Pending operation is discarded and an uncommitted store is not performed.
//   - in_ready rises the first cycle after RESET returns high.
// CONFIGURATION
//   MEM_BYTE_ACCESS_EN defined
//   - Adds input ByteOp (1 bit). With ByteOp=1:
//     - alignment check is skipped;
//     - a store writes B[7:0] to mem[addr];
//     - a load returns mem[addr] sign-extended to 32 bits.
//   - ByteOp=0 behaves as word access.
//   MEM_BYTE_ACCESS_EN undefined
//   - ByteOp port is absent; all accesses are word accesses.
// TESTING
//   1. Hold RESET=0 5 cycles with in_valid=1 -> in_ready=0 and all outputs 0; release -> in_ready=1 next cycle.
//   2. R-type: ALUOut=0x7, WriteReg=2, RegWrite=1, MemtoReg=0 -> next cycle RegWriteOut=1, WriteData=0x7,
//      WriteRegOut=2, ERR=0; in_ready=1 the cycle after.
//   3. WAIT_STATES=2: sw ALUOut=0x10, B=0xDEADBEEF -> RegWriteOut stays 0, in_ready low 4 cycles, mem[0x10]=0xDE,
//      mem[0x13]=0xEF; then lw ALUOut=0x10, WriteReg=9, MemtoReg=1, RegWrite=1 -> WriteData=0xDEADBEEF,
//      WriteRegOut=9 at accept+4.
//   4. lw ALUOut=0x13 -> ERR=1 for one cycle at accept+1, RegWriteOut=0, memory untouched;
//      MemRead=MemWrite=1 -> same response.
//   5. sw ALUOut=0x20, B=0x12345678; drop RESET one cycle after accept -> mem[0x20..0x23] stay 0;
//      after release a lw from 0x20 returns 0.
//   6. sw ALUOut=0x404, B=0xCAFEF00D (MEM_BYTES=1024) -> lw ALUOut=0x4 returns 0xCAFEF00D.
//      With MEM_BYTE_ACCESS_EN and ByteOp=1, lw ALUOut=0x4 -> 0xFFFFFFCA.

Source files
------------

// File: rtl/mem_writeback_stage_if.sv
// Upstream operation / write-back bus of mem_writeback_stage.
// ByteOp exists only when MEM_BYTE_ACCESS_EN is defined.
interface mem_writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUOut;
  logic [31:0] B;
  logic [4:0]  WriteReg;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
`ifdef MEM_BYTE_ACCESS_EN
  logic        ByteOp;
`endif
  logic [31:0] WriteData;
  logic [4:0]  WriteRegOut;
  logic        RegWriteOut;
  logic        ERR;

`ifdef MEM_BYTE_ACCESS_EN
  modport master (output in_valid, ALUOut, B, WriteReg, MemRead, MemWrite, MemtoReg, RegWrite, ByteOp,
                  input  in_ready, WriteData, WriteRegOut, RegWriteOut, ERR);
  modport slave  (input  in_valid, ALUOut, B, WriteReg, MemRead, MemWrite, MemtoReg, RegWrite, ByteOp,
                  output in_ready, WriteData, WriteRegOut, RegWriteOut, ERR);
`else
  modport master (output in_valid, ALUOut, B, WriteReg, MemRead, MemWrite, MemtoReg, RegWrite,
                  input  in_ready, WriteData, WriteRegOut, RegWriteOut, ERR);
  modport slave  (input  in_valid, ALUOut, B, WriteReg, MemRead, MemWrite, MemtoReg, RegWrite,
                  output in_ready, WriteData, WriteRegOut, RegWriteOut, ERR);
`endif
endinterface

// File: rtl/mem_writeback_stage.sv
// Data-memory access and write-back stage: big-endian byte memory with fixed wait states.
// Optional byte loads/stores (ByteOp input) enabled by defining MEM_BYTE_ACCESS_EN.
module mem_writeback_stage #(
  parameter int MEM_BYTES   = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input logic CLK,
  input logic RESET,
  mem_writeback_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WB = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         alu_q, alu_d;
  logic [31:0]         b_q, b_d;
  logic [4:0]          wreg_q, wreg_d;
  logic                load_q, load_d;
  logic                store_q, store_d;
  logic                m2r_q, m2r_d;
  logic                rw_q, rw_d;
  logic                byte_q, byte_d;
  logic                in_ready_q, in_ready_d;
  logic [31:0]         wd_q, wd_d;
  logic [4:0]          wro_q, wro_d;
  logic                rwo_q, rwo_d;
  logic                err_q, err_d;

  // Memory is not reset; the declaration initialiser gives the all-zero power-up image.
  logic [7:0]          mem_q [MEM_BYTES] = '{default: 8'h00};

  logic                mem_we_s;
  logic                acc_err_s;
  logic                mem_ok_s;
  logic                in_byte_s;
  logic [ADDR_W-1:0]   a1_s, a2_s, a3_s;
  logic [31:0]         rd_word_s;

  assign a1_s = addr_q + ADDR_W'(1);
  assign a2_s = addr_q + ADDR_W'(2);
  assign a3_s = addr_q + ADDR_W'(3);

`ifdef MEM_BYTE_ACCESS_EN
  assign in_byte_s = bus.ByteOp;
  assign rd_word_s = byte_q ? {{24{mem_q[addr_q][7]}}, mem_q[addr_q]}
                            : {mem_q[addr_q], mem_q[a1_s], mem_q[a2_s], mem_q[a3_s]};
`else
  assign in_byte_s = 1'b0;
  assign rd_word_s = {mem_q[addr_q], mem_q[a1_s], mem_q[a2_s], mem_q[a3_s]};
`endif

  // Both flags set is always an error; a single flag errors only when misaligned word access.
  assign acc_err_s = (bus.MemRead & bus.MemWrite) |
                     ((bus.MemRead ^ bus.MemWrite) & (bus.ALUOut[1:0] != 2'b00) & ~in_byte_s);
  assign mem_ok_s  = (bus.MemRead ^ bus.MemWrite) & ~acc_err_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    alu_d    = alu_q;
    b_d      = b_q;
    wreg_d   = wreg_q;
    load_d   = load_q;
    store_d  = store_q;
    m2r_d    = m2r_q;
    rw_d     = rw_q;
    byte_d   = byte_q;
    wd_d     = wd_q;
    wro_d    = wro_q;
    rwo_d    = 1'b0;
    err_d    = 1'b0;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          addr_d  = bus.ALUOut[ADDR_W-1:0];
          alu_d   = bus.ALUOut;
          b_d     = bus.B;
          wreg_d  = bus.WriteReg;
          load_d  = bus.MemRead;
          store_d = bus.MemWrite;
          m2r_d   = bus.MemtoReg;
          rw_d    = bus.RegWrite;
          byte_d  = in_byte_s;
          if (mem_ok_s) begin
            state_d = ACCESS;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            // Non-memory or faulting op: results go straight to the output registers.
            state_d = WB;
            wd_d    = bus.ALUOut;
            wro_d   = bus.WriteReg;
            rwo_d   = bus.RegWrite & ~acc_err_s;
            err_d   = acc_err_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = WB;
          mem_we_s = store_q;
          wro_d    = wreg_q;
          wd_d     = (load_q && m2r_q) ? rd_word_s : alu_q;
          rwo_d    = rw_q & ~store_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      alu_q      <= 32'd0;
      b_q        <= 32'd0;
      wreg_q     <= 5'd0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      m2r_q      <= 1'b0;
      rw_q       <= 1'b0;
      byte_q     <= 1'b0;
      in_ready_q <= 1'b0;
      wd_q       <= 32'd0;
      wro_q      <= 5'd0;
      rwo_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      alu_q      <= alu_d;
      b_q        <= b_d;
      wreg_q     <= wreg_d;
      load_q     <= load_d;
      store_q    <= store_d;
      m2r_q      <= m2r_d;
      rw_q       <= rw_d;
      byte_q     <= byte_d;
      in_ready_q <= in_ready_d;
      wd_q       <= wd_d;
      wro_q      <= wro_d;
      rwo_q      <= rwo_d;
      err_q      <= err_d;
    end
  end

  // Commit-edge store; reset forces IDLE asynchronously, so a reset store never lands.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
`ifdef MEM_BYTE_ACCESS_EN
      if (byte_q) begin
        mem_q[addr_q] <= b_q[7:0];
      end else begin
        mem_q[addr_q] <= b_q[31:24];
        mem_q[a1_s]   <= b_q[23:16];
        mem_q[a2_s]   <= b_q[15:8];
        mem_q[a3_s]   <= b_q[7:0];
      end
`else
      mem_q[addr_q] <= b_q[31:24];
      mem_q[a1_s]   <= b_q[23:16];
      mem_q[a2_s]   <= b_q[15:8];
      mem_q[a3_s]   <= b_q[7:0];
`endif
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.WriteData   = wd_q;
  assign bus.WriteRegOut = wro_q;
  assign bus.RegWriteOut = rwo_q;
  assign bus.ERR         = err_q;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Self-checking bench for mem_writeback_stage: directed steps then random ops against a byte-array model.
module tb_mem_writeback_stage;
  localparam int WS  = 2;
  localparam int MEM = 1024;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] ref_mem [MEM];

  mem_writeback_stage_if ifc ();

  mem_writeback_stage #(.MEM_BYTES(MEM), .ADDR_W(10), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RESET(RESET), .bus(ifc.slave));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] alu, input logic bop);
    int a;
    a = int'(alu[9:0]);
    if (bop) return {{24{ref_mem[a][7]}}, ref_mem[a]};
    return {ref_mem[a], ref_mem[(a+1)%MEM], ref_mem[(a+2)%MEM], ref_mem[(a+3)%MEM]};
  endfunction

  task automatic ref_store(input logic [31:0] alu, input logic [31:0] data, input logic bop);
    int a;
    a = int'(alu[9:0]);
    if (bop) ref_mem[a] = data[7:0];
    else begin
      ref_mem[a]         = data[31:24];
      ref_mem[(a+1)%MEM] = data[23:16];
      ref_mem[(a+2)%MEM] = data[15:8];
      ref_mem[(a+3)%MEM] = data[7:0];
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] b, input logic [4:0] wreg, input logic bop);
    ifc.in_valid = 1'b1;
    ifc.MemRead  = rd;   ifc.MemWrite = wr;  ifc.MemtoReg = m2r; ifc.RegWrite = rw;
    ifc.ALUOut   = alu;  ifc.B = b;          ifc.WriteReg = wreg;
`ifdef MEM_BYTE_ACCESS_EN
    ifc.ByteOp   = bop;
`endif
  endtask

  // Called at a negedge; returns at the negedge after the write-back cycle.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [31:0] alu, input logic [31:0] b, input logic [4:0] wreg, input logic bop);
    int n;
    logic err, memop, st;
    int lat;
    logic [31:0] exp_wd;
    n = 0;
    while (ifc.in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check({tag, ".ready"}, 32'(ifc.in_ready), 32'd1);
    err   = (rd & wr) | ((rd ^ wr) & (alu[1:0] != 2'b00) & ~bop);
    memop = (rd ^ wr) & ~err;
    st    = memop & wr;
    lat   = memop ? WS + 2 : 1;
    exp_wd = (memop && rd && m2r) ? ref_load(alu, bop) : alu;
    drive(rd, wr, m2r, rw, alu, b, wreg, bop);
    @(posedge CLK);
    @(negedge CLK);
    ifc.in_valid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check({tag, ".busy_rwo"}, 32'(ifc.RegWriteOut), 32'd0);
      check({tag, ".busy_err"}, 32'(ifc.ERR), 32'd0);
      check({tag, ".busy_rdy"}, 32'(ifc.in_ready), 32'd0);
      @(negedge CLK);
    end
    check({tag, ".rwo"}, 32'(ifc.RegWriteOut), 32'(rw & ~st & ~err));
    check({tag, ".err"}, 32'(ifc.ERR), 32'(err));
    check({tag, ".wd"},  ifc.WriteData, exp_wd);
    check({tag, ".wr"},  32'(ifc.WriteRegOut), 32'(wreg));
    check({tag, ".wb_rdy"}, 32'(ifc.in_ready), 32'd0);
    if (st) ref_store(alu, b, bop);
    @(negedge CLK);
    check({tag, ".post_rwo"}, 32'(ifc.RegWriteOut), 32'd0);
    check({tag, ".post_err"}, 32'(ifc.ERR), 32'd0);
    check({tag, ".post_wd"},  ifc.WriteData, exp_wd);
    check({tag, ".post_rdy"}, 32'(ifc.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] alu;
    logic        bop;
    int          kind;
    for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);

    // 1: reset held with in_valid high
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("rst.rdy", 32'(ifc.in_ready), 32'd0);
      check("rst.wd",  ifc.WriteData, 32'd0);
      check("rst.flags", {26'd0, ifc.WriteRegOut, ifc.RegWriteOut}, 32'd0);
      check("rst.err", 32'(ifc.ERR), 32'd0);
    end
    RESET = 1'b1;
    check("rel.rdy0", 32'(ifc.in_ready), 32'd0);
    @(negedge CLK);
    ifc.in_valid = 1'b0;
    check("rel.rdy1", 32'(ifc.in_ready), 32'd1);

    // 2..4: directed functional steps
    run_op("rtype", 1'b0, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 5'd2, 1'b0);
    run_op("sw10",  1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
    run_op("lw10",  1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd9, 1'b0);
    run_op("lwmis", 1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 5'd4, 1'b0);
    run_op("both",  1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h5555AAAA, 5'd5, 1'b0);
    run_op("lw10b", 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd9, 1'b0);

    // 5: reset during a pending store
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h12345678, 5'd0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    ifc.in_valid = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    check("mid.rdy", 32'(ifc.in_ready), 32'd0);
    check("mid.rwo", 32'(ifc.RegWriteOut), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid.rdy1", 32'(ifc.in_ready), 32'd1);
    run_op("lw20", 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd3, 1'b0);

    // 6: address wrap
    run_op("sw404", 1'b0, 1'b1, 1'b0, 1'b1, 32'h404, 32'hCAFEF00D, 5'd1, 1'b0);
    run_op("lw4",   1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0, 5'd6, 1'b0);
`ifdef MEM_BYTE_ACCESS_EN
    run_op("lb4",   1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0, 5'd7, 1'b1);
    run_op("sb7",   1'b0, 1'b1, 1'b0, 1'b0, 32'h7, 32'h000000A5, 5'd0, 1'b1);
    run_op("lw4b",  1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0, 5'd8, 1'b0);
`endif

    // random operations against the model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      alu  = $urandom;
      bop  = 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
      bop  = 1'($urandom_range(0, 1));
`endif
      if (kind == 1 || kind == 2) begin
        alu[31:6] = {$urandom} >> 6;
        alu[1:0]  = bop ? alu[1:0] : 2'b00;
        alu[9:6]  = 4'($urandom_range(0, 1));
      end
      case (kind)
        0: run_op("r_rtype", 1'b0, 1'b0, 1'b0, 1'($urandom), alu, $urandom, 5'($urandom), bop);
        1: run_op("r_sw",    1'b0, 1'b1, 1'b0, 1'($urandom), alu, $urandom, 5'($urandom), bop);
        2: run_op("r_lw",    1'b1, 1'b0, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom), bop);
        3: run_op("r_both",  1'b1, 1'b1, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom), bop);
        default: begin
          if (alu[1:0] == 2'b00) alu[0] = 1'b1;
          run_op("r_mis", 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom), 1'b0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
